// File: rtl/avalon_rr_arbiter_pkg.sv
// Shared types and constants for the round-robin Avalon arbiter.
// The FSM state encoding and the read-timeout response word live here.
package avalon_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2
  } arb_state_e;

  // Read data returned when the slave never answers (timeout build only).
  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/avalon_rr_arbiter_if.sv
// Bus bundle between the requesters, the arbiter and the shared slave port.
// 'slave' is the arbiter's view; 'master' is the view of the surrounding system.
interface avalon_rr_arbiter_if #(
  parameter int REQS   = 2,
  parameter int ADDR_W = 2,
  parameter int DATA_W = 32
) ();

  // Requester side
  logic [REQS-1:0]              m_read;
  logic [REQS-1:0]              m_write;
  logic [REQS-1:0][ADDR_W-1:0]  m_address;
  logic [REQS-1:0][DATA_W-1:0]  m_data_in;
  logic [REQS-1:0]              m_waitrequest;
  logic [REQS-1:0]              m_read_valid;
  logic [DATA_W-1:0]            m_data_out;

  // Shared slave side
  logic                         s_read;
  logic                         s_write;
  logic [ADDR_W-1:0]            s_address;
  logic [DATA_W-1:0]            s_data_out;
  logic                         s_read_valid;
  logic [DATA_W-1:0]            s_data_in;

  modport slave (
    input  m_read, m_write, m_address, m_data_in,
    output m_waitrequest, m_read_valid, m_data_out,
    output s_read, s_write, s_address, s_data_out,
    input  s_read_valid, s_data_in
  );

  modport master (
    output m_read, m_write, m_address, m_data_in,
    input  m_waitrequest, m_read_valid, m_data_out,
    input  s_read, s_write, s_address, s_data_out,
    output s_read_valid, s_data_in
  );

endinterface

// File: rtl/avalon_rr_arbiter_rr_picker.sv
// Combinational rotate-priority encoder: the first requester above ptr wins,
// searching ptr+1, ptr+2, ... and wrapping back round to ptr itself.
module rr_picker #(
  parameter int REQS = 2
) (
  input  logic [REQS-1:0]         req,
  input  logic [$clog2(REQS)-1:0] ptr,
  output logic                    any,
  output logic [$clog2(REQS)-1:0] win
);

  localparam int IDX_W = $clog2(REQS);

  int               cand;
  logic [IDX_W-1:0] cand_idx;

  // NOTE: every output of a combinational block gets a default before any
  // branch; a path that leaves a variable unassigned infers a latch.
  always_comb begin
    any      = |req;
    win      = '0;
    cand     = 0;
    cand_idx = '0;
    // Walk from lowest to highest priority so the last hit is the winner.
    for (int i = REQS; i >= 1; i--) begin
      cand = int'(ptr) + i;
      if (cand >= REQS) cand = cand - REQS;
      cand_idx = IDX_W'(cand);
      if (req[cand_idx]) win = cand_idx;
    end
  end

endmodule

// File: rtl/avalon_rr_arbiter.sv
// Round-robin arbiter sharing one Avalon-style slave port among REQS requesters.
// Define AVALON_ARB_TIMEOUT_EN to bound the wait for read data to RD_TIMEOUT cycles.
module avalon_rr_arbiter
  import avalon_arb_pkg::*;
#(
  parameter int REQS       = 2,
  parameter int ADDR_W     = 2,
  parameter int DATA_W     = 32,
  parameter int RD_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset,
  avalon_rr_arbiter_if.slave bus
);

  localparam int IDX_W = $clog2(REQS);

  if (REQS < 2 || REQS > 8 || RD_TIMEOUT < 1) begin : g_bad_params
    $error("avalon_rr_arbiter: REQS must be 2..8 and RD_TIMEOUT at least 1");
  end

  arb_state_e        state, state_d;
  logic [IDX_W-1:0]  ptr, ptr_d;
  logic [IDX_W-1:0]  gnt, gnt_d;
  logic              op_wr, op_wr_d;

  logic [REQS-1:0]   req_vec;
  logic              any_req;
  logic [IDX_W-1:0]  win;

  // Next values of the registered outputs.
  logic [REQS-1:0]   wait_d;
  logic [REQS-1:0]   rvalid_d;
  logic [DATA_W-1:0] rdata_d;
  logic              s_read_d, s_write_d;
  logic [ADDR_W-1:0] s_addr_d;
  logic [DATA_W-1:0] s_wdata_d;

`ifdef AVALON_ARB_TIMEOUT_EN
  localparam int                CNT_W    = $clog2(RD_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(RD_TIMEOUT - 1);
  localparam logic [DATA_W-1:0] TMO_DATA = DATA_W'(TIMEOUT_DATA);

  logic [CNT_W-1:0] tmo_cnt, tmo_cnt_d;
`endif

  // A simultaneous read and write from one requester counts as a write.
  assign req_vec = bus.m_read | bus.m_write;

  rr_picker #(.REQS(REQS)) u_picker (
    .req (req_vec),
    .ptr (ptr),
    .any (any_req),
    .win (win)
  );

  always_comb begin
    state_d   = state;
    ptr_d     = ptr;
    gnt_d     = gnt;
    op_wr_d   = op_wr;
    wait_d    = '1;
    rvalid_d  = '0;
    rdata_d   = bus.m_data_out;
    s_read_d  = 1'b0;
    s_write_d = 1'b0;
    s_addr_d  = bus.s_address;
    s_wdata_d = bus.s_data_out;
`ifdef AVALON_ARB_TIMEOUT_EN
    tmo_cnt_d = '0;
`endif

    unique case (state)
      IDLE: begin
        // Outputs for the ISSUE cycle are set up here so they leave a flop.
        if (any_req) begin
          gnt_d       = win;
          op_wr_d     = bus.m_write[win];
          s_write_d   = bus.m_write[win];
          s_read_d    = ~bus.m_write[win];
          s_addr_d    = bus.m_address[win];
          s_wdata_d   = bus.m_data_in[win];
          wait_d[win] = 1'b0;
          state_d     = ISSUE;
        end
      end

      ISSUE: begin
        ptr_d   = gnt;
        state_d = op_wr ? IDLE : WAIT_RD;
      end

      WAIT_RD: begin
        if (bus.s_read_valid) begin
          rdata_d       = bus.s_data_in;
          rvalid_d[gnt] = 1'b1;
          state_d       = IDLE;
        end
`ifdef AVALON_ARB_TIMEOUT_EN
        else if (tmo_cnt == CNT_LAST) begin
          rdata_d       = TMO_DATA;
          rvalid_d[gnt] = 1'b1;
          state_d       = IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt + 1'b1;
        end
`endif
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: flops are written with non-blocking assignments so every register
  // samples the pre-edge value of every other one, independent of block order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= IDX_W'(REQS - 1);
      gnt   <= '0;
      op_wr <= 1'b0;
    end else begin
      state <= state_d;
      ptr   <= ptr_d;
      gnt   <= gnt_d;
      op_wr <= op_wr_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.m_waitrequest <= '1;
      bus.m_read_valid  <= '0;
      bus.m_data_out    <= '0;
      bus.s_read        <= 1'b0;
      bus.s_write       <= 1'b0;
      bus.s_address     <= '0;
      bus.s_data_out    <= '0;
    end else begin
      bus.m_waitrequest <= wait_d;
      bus.m_read_valid  <= rvalid_d;
      bus.m_data_out    <= rdata_d;
      bus.s_read        <= s_read_d;
      bus.s_write       <= s_write_d;
      bus.s_address     <= s_addr_d;
      bus.s_data_out    <= s_wdata_d;
    end
  end

`ifdef AVALON_ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) tmo_cnt <= '0;
    else       tmo_cnt <= tmo_cnt_d;
  end
`endif

endmodule

// File: tb/tb_avalon_rr_arbiter.sv
// Bench for avalon_rr_arbiter: directed scenarios then random traffic, every
// output compared each cycle against a transaction-timeline reference model.
module tb_avalon_rr_arbiter;

  localparam int REQS       = 3;
  localparam int ADDR_W     = 2;
  localparam int DATA_W     = 32;
  localparam int RD_TIMEOUT = 15;
  localparam int NEVER      = 32'h7fff_ffff;
  localparam logic [31:0] DEAD_WORD = 32'hDEAD_BEEF;

  typedef enum int {GEN_IDLE, GEN_RAND, GEN_WR_ALL} gen_e;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  avalon_rr_arbiter_if #(.REQS(REQS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  avalon_rr_arbiter #(
    .REQS(REQS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_TIMEOUT(RD_TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Requester agents: one outstanding request each, held until accepted.
  bit                a_rd   [REQS];
  bit                a_wr   [REQS];
  logic [ADDR_W-1:0] a_addr [REQS];
  logic [DATA_W-1:0] a_data [REQS];
  int                a_done [REQS];   // cycle its strobe appears, -1 if pending
  gen_e              gen_mode = GEN_IDLE;
  logic [REQS-1:0]   gen_mask = '1;

  // Reference model: timeline of the single transaction in flight.
  int                next_free, last;
  int                strobe_cyc, strobe_g, resp_cyc, resp_g;
  bit                strobe_wr;
  logic [ADDR_W-1:0] strobe_addr, h_addr;
  logic [DATA_W-1:0] strobe_data, h_wdata, resp_data, h_rdata;

  // Slave model.
  int                sv_cyc = -1, late_cyc = -1, win_lo = -1, win_hi = -2;
  logic [DATA_W-1:0] sv_data;
  int                force_lat = 0;      // 0 random, >0 fixed, -1 silent
  bit                force_data_en = 0;
  logic [DATA_W-1:0] force_data;

  task automatic apply_agents();
    for (int i = 0; i < REQS; i++) begin
      bus.m_read[i]    = a_rd[i];
      bus.m_write[i]   = a_wr[i];
      bus.m_address[i] = a_addr[i];
      bus.m_data_in[i] = a_data[i];
    end
  endtask

  task automatic apply_reset(input bit v);
    if (v) begin
      strobe_cyc = -1; resp_cyc = -1; win_lo = -1; win_hi = -2;
      h_addr = '0; h_wdata = '0; h_rdata = '0;
      last = REQS - 1; next_free = NEVER;
      for (int i = 0; i < REQS; i++)
        if (a_done[i] >= 0) begin a_rd[i] = 0; a_wr[i] = 0; a_done[i] = -1; end
      apply_agents();
    end else begin
      next_free = cyc;
    end
    reset = v;
  endtask

  task automatic post(input int i, input bit rd, input bit wr,
                      input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
    a_rd[i] = rd; a_wr[i] = wr; a_addr[i] = addr; a_data[i] = data; a_done[i] = -1;
    apply_agents();
  endtask

  task automatic new_req(input int i);
    int r;
    if (!gen_mask[i]) return;
    case (gen_mode)
      GEN_RAND: if ($urandom_range(0, 1) == 1) begin
        r = int'($urandom_range(0, 4));
        a_rd[i] = (r < 2) || (r == 4);
        a_wr[i] = (r >= 2);
        a_addr[i] = ADDR_W'($urandom);
        a_data[i] = DATA_W'($urandom);
      end
      GEN_WR_ALL: begin
        a_rd[i] = 0; a_wr[i] = 1;
        a_addr[i] = ADDR_W'($urandom);
        a_data[i] = DATA_W'($urandom);
      end
      default: ;
    endcase
  endtask

  task automatic drive_inputs();
    bit spur;
    for (int i = 0; i < REQS; i++) begin
      if (a_done[i] >= 0 && cyc > a_done[i]) begin
        a_rd[i] = 0; a_wr[i] = 0; a_done[i] = -1;
      end
      if (!a_rd[i] && !a_wr[i]) new_req(i);
    end
    apply_agents();
    spur = (gen_mode == GEN_RAND) && !(cyc >= win_lo && cyc <= win_hi) &&
           ($urandom_range(0, 3) == 0);
    bus.s_read_valid = (cyc == sv_cyc) || (cyc == late_cyc) || spur;
    bus.s_data_in    = (cyc == sv_cyc) ? sv_data : DATA_W'($urandom);
  endtask

  // Decide who is granted in cycle 'cyc' and when everything happens.
  task automatic model_decide();
    int w, lat;
    w = -1;
    if (cyc < next_free) return;
    for (int k = 1; k <= REQS; k++) begin
      int c;
      c = (last + k) % REQS;
      if (w < 0 && (a_rd[c] || a_wr[c])) w = c;
    end
    if (w < 0) return;
    strobe_cyc = cyc + 1; strobe_g = w; strobe_wr = a_wr[w];
    strobe_addr = a_addr[w]; strobe_data = a_data[w];
    a_done[w] = cyc + 1; last = w;
    if (strobe_wr) begin
      next_free = cyc + 2;
    end else begin
      lat = (force_lat != 0) ? force_lat : int'($urandom_range(1, 3));
      resp_g = w;
      if (lat < 0) begin
        sv_cyc = -1;
        resp_cyc = strobe_cyc + 1 + RD_TIMEOUT;
        resp_data = DATA_W'(DEAD_WORD);
      end else begin
        sv_cyc = strobe_cyc + lat;
        sv_data = force_data_en ? force_data : DATA_W'($urandom);
        resp_cyc = sv_cyc + 1;
        resp_data = sv_data;
      end
      win_lo = strobe_cyc + 1; win_hi = resp_cyc - 1;
      next_free = resp_cyc;
    end
  endtask

  task automatic check_outputs();
    logic [REQS-1:0] exp_wait, exp_rv;
    if (cyc == strobe_cyc) begin h_addr = strobe_addr; h_wdata = strobe_data; end
    if (cyc == resp_cyc) h_rdata = resp_data;
    exp_wait = '1; exp_rv = '0;
    if (cyc == strobe_cyc) exp_wait[strobe_g] = 1'b0;
    if (cyc == resp_cyc)   exp_rv[resp_g]     = 1'b1;
    check("s_write", bus.s_write, (cyc == strobe_cyc) && strobe_wr);
    check("s_read", bus.s_read, (cyc == strobe_cyc) && !strobe_wr);
    check("waitrequest", bus.m_waitrequest, exp_wait);
    check("s_address", bus.s_address, h_addr);
    check("s_data_out", bus.s_data_out, h_wdata);
    check("m_read_valid", bus.m_read_valid, exp_rv);
    check("m_data_out", bus.m_data_out, h_rdata);
  endtask

  task automatic cycle_step();
    @(negedge clk);
    check_outputs();
    if (!reset) model_decide();
    @(posedge clk);
    #1;
    cyc++;
    drive_inputs();
  endtask

  task automatic run(input int n);
    repeat (n) cycle_step();
  endtask

  initial begin
    for (int i = 0; i < REQS; i++) begin
      a_rd[i] = 0; a_wr[i] = 0; a_addr[i] = '0; a_data[i] = '0; a_done[i] = -1;
    end
    bus.s_read_valid = 1'b0;
    bus.s_data_in    = '0;
    apply_reset(1'b1);
    @(posedge clk);
    #1;
    cyc = 0;
    drive_inputs();
    run(3);
    apply_reset(1'b0);
    run(2);

    // Single write from requester 0.
    post(0, 1'b0, 1'b1, 2'd1, 32'h5);
    run(5);

    // Read from requester 1, slave answers one cycle after s_read.
    force_lat = 1; force_data_en = 1; force_data = 32'h1234;
    post(1, 1'b1, 1'b0, 2'd0, 32'h0);
    run(6);
    force_lat = 0; force_data_en = 0;

    // Requesters 0 and 1 write back to back: grants must alternate.
    gen_mask = 3'b011; gen_mode = GEN_WR_ALL;
    run(16);
    gen_mode = GEN_IDLE; gen_mask = '1;
    run(6);

    // Read and write asserted together: only the write goes out.
    post(0, 1'b1, 1'b1, 2'd2, 32'hCAFE_0001);
    run(5);

    // Reset while waiting for read data, then a normal request.
    force_lat = 20;
    post(1, 1'b1, 1'b0, 2'd3, 32'h0);
    run(5);
    apply_reset(1'b1);
    run(2);
    apply_reset(1'b0);
    force_lat = 0;
    run(2);
    post(0, 1'b0, 1'b1, 2'd2, 32'hA5A5_0F0F);
    run(25);

`ifdef AVALON_ARB_TIMEOUT_EN
    // Silent slave: timeout word returned, a late strobe is ignored.
    force_lat = -1;
    post(2, 1'b1, 1'b0, 2'd1, 32'h0);
    run(1);
    late_cyc = resp_cyc;
    run(RD_TIMEOUT + 6);
    late_cyc = -1;
    force_lat = 0;
`endif

    // Random traffic from all requesters, including stray s_read_valid.
    gen_mode = GEN_RAND;
    run(1500);
    gen_mode = GEN_IDLE;
    run(40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/avalon_rr_arbiter.md
# avalon_rr_arbiter

Round-robin arbiter that shares one Avalon-style peripheral slave port (read/write/address/data_in/read_valid/data_out) among `REQS` bus requesters. Sits between several masters (CPU, DMA, debug port) and a single `avalon_adapter`-fronted core. Serialises accesses, holds off losers with per-requester waitrequest, and routes read data back to the originating requester.

## Interface
- `REQS`, 2, number of requesters (2..8)
- `ADDR_W`, 2, slave address width
- `DATA_W`, 32, data width
- `RD_TIMEOUT`, 15, max cycles waited for `s_read_valid` (timeout build only)

- `clk`  in  1  single clock
- `reset`  in  1  asynchronous, active-high reset
- `m_read`  in  REQS  per-requester read request, held until accepted
- `m_write`  in  REQS  per-requester write request, held until accepted
- `m_address`  in  REQS×ADDR_W  per-requester address
- `m_data_in`  in  REQS×DATA_W  per-requester write data
- `m_waitrequest`  out  REQS  1 = request not yet accepted
- `m_read_valid`  out  REQS  one-cycle read-return strobe, one-hot
- `m_data_out`  out  DATA_W  read data, shared; qualified by `m_read_valid`
- `s_read`, `s_write`  out  1  one-cycle command strobes to slave
- `s_address`  out  ADDR_W  slave address
- `s_data_out`  out  DATA_W  write data to slave `data_in`
- `s_read_valid`  in  1  slave read-return strobe
- `s_data_in`  in  DATA_W  slave `data_out`

## Operation
- FSM states: IDLE, ISSUE, WAIT_RD.
- IDLE: if any `m_read|m_write` bit set, select winner `g` by round-robin search from `ptr+1` upward, wrapping; latch `g`, op, address, data; go ISSUE. No request: stay.
- ISSUE: `s_read` or `s_write` high for exactly this cycle with latched address/data; `m_waitrequest[g]`=0 this cycle only; `ptr`←`g`. Write → IDLE. Read → WAIT_RD.
- WAIT_RD: on `s_read_valid`, register `s_data_in` to `m_data_out` and pulse `m_read_valid[g]` next cycle; → IDLE.
- `m_read[i]` and `m_write[i]` both set: treated as write; read ignored.
- `s_read_valid` outside WAIT_RD: ignored.
- Requests from non-granted requesters are never dropped; they wait with `m_waitrequest`=1.
- Fairness: a requester asserting continuously waits at most `REQS-1` transactions.
- Reset: state IDLE, `ptr`=REQS-1 (requester 0 wins first), `m_waitrequest`=all ones, `m_read_valid`=0, `m_data_out`=0, `s_read`=`s_write`=0, `s_address`=0, `s_data_out`=0. Reset mid-transaction abandons it; no response is generated.

## Timing
- All outputs registered.
- Request visible in cycle N (IDLE) → slave strobe and `m_waitrequest[g]`=0 in N+1. Requester may drop request in N+2.
- Write throughput: one write per 2 cycles.
- Read: `s_read_valid` in cycle M → `m_read_valid[g]`/`m_data_out` in M+1. With a slave returning 1 cycle after `s_read`: request N → data N+3, next grant N+3 at the earliest.
- `m_read_valid` pulse coincides with the IDLE cycle; a new grant can be decided in that same cycle.

## Configuration
- `AVALON_ARB_TIMEOUT_EN` defined: a cycle counter runs in WAIT_RD. If `s_read_valid` is absent for `RD_TIMEOUT` cycles, the block returns `m_data_out`=32'hDEAD_BEEF (truncated to DATA_W) with `m_read_valid[g]`, and returns to IDLE. A late `s_read_valid` is ignored.
- Undefined: WAIT_RD waits indefinitely; no counter logic.

## Structure
- `avalon_arb_pkg`: state enum (`IDLE`, `ISSUE`, `WAIT_RD`), `TIMEOUT_DATA` constant (32'hDEAD_BEEF).
- Sub-module `rr_picker`: combinational rotate-priority-encoder; inputs request vector and `ptr`; outputs `any` and winner index.

## Test plan
- Reset then single write from req 0, addr 1, data 32'h5 → `s_write` pulse one cycle after request, `s_address`=1, `s_data_out`=5, `m_waitrequest[0]` low same cycle.
- Req 1 read addr 0; slave returns 32'h1234 one cycle after `s_read` → `m_read_valid`=2'b10, `m_data_out`=32'h1234 one cycle after `s_read_valid`.
- Req 0 and req 1 both continuously write from reset → grants alternate 0,1,0,1; each sees waitrequest low once per 4 cycles.
- Req 0 asserts read and write together → only `s_write` issued, no `m_read_valid`.
- Reset asserted in WAIT_RD, then released → no `m_read_valid`, all outputs at reset values, next request granted normally.
- With `AVALON_ARB_TIMEOUT_EN`, slave never responds → after 15 WAIT_RD cycles `m_read_valid[g]`=1, data 32'hDEAD_BEEF.
